shift_unit_seq: RTL and testbench
=================================

SHIFT_UNIT_SEQ -- requirements
Module: shift_unit_seq

Interface
REQ-001 The block SHALL have no parameters; datapath width is fixed at 32 bits and shift amount at 5 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to begin a shift; sampled only in IDLE.
REQ-005 op  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
REQ-006 a  input  32  operand; captured on the accepting edge.
REQ-007 shamt  input  5  shift amount 0..31; captured on the accepting edge.
REQ-008 busy  output  1  high while an operation is in progress (states SHIFT and DONE).
REQ-009 done  output  1  one-cycle pulse; result is valid while high.
REQ-010 result  output  32  shifted value, registered.

Function
REQ-011 The block SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-012 IDLE with start=1 at a rising edge SHALL latch a into result, shamt into a 5-bit counter cnt, and op into an op register.
REQ-013 On acceptance, the next state SHALL be DONE if shamt=0, otherwise SHIFT.
REQ-014 In SHIFT, each edge SHALL shift result by exactly one bit using the latched op, and SHALL decrement cnt.
REQ-015 SLL SHALL fill bit 0 with 0; SRL SHALL fill bit 31 with 0.
REQ-016 SRA SHALL fill bit 31 with the current bit 31; ROL SHALL move bit 31 into bit 0.
REQ-017 In SHIFT, when cnt=1 at an edge, that edge SHALL perform the final shift and move to DONE.
REQ-018 For a request accepted at edge k, done SHALL be high during the cycle after edge k+shamt, giving shamt+1 edges of latency.
REQ-019 DONE SHALL assert done for exactly one cycle, then move to IDLE on the next edge.
REQ-020 result SHALL hold its value from DONE until the next accepted start.
REQ-021 start SHALL be ignored in SHIFT and DONE; it SHALL NOT be queued or extend the operation.
REQ-022 start asserted in the same cycle the block returns to IDLE SHALL be accepted at the following edge; there is no back-to-back acceptance from DONE.
REQ-023 Changes on a, shamt, or op after acceptance SHALL NOT affect the operation in progress.
REQ-024 busy SHALL be combinationally derived as (state != IDLE); done SHALL be (state == DONE).
REQ-025 shamt >= 32 is not representable; no saturation logic SHALL exist.

Reset
REQ-026 Asserting reset SHALL immediately force state=IDLE, cnt=0, op register=00, result=0, busy=0, and done=0, independent of clk.
REQ-027 Reset asserted mid-operation SHALL abandon the operation; no done pulse SHALL follow.
REQ-028 After reset deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-029 SLL, a=0x0000_0001, shamt=4 -> done 5 edges after acceptance, result=0x0000_0010.
REQ-030 SRA, a=0x8000_0000, shamt=31 -> done after 32 edges, result=0xFFFF_FFFF; the same case with SRL -> result=0x0000_0001.
REQ-031 ROL, a=0x8000_0001, shamt=1 -> done after 2 edges, result=0x0000_0003; the shamt=0 case -> done after 1 edge, result=a unchanged.
REQ-032 Pulse start during SHIFT with different a and shamt -> original result unaffected, exactly one done pulse, busy stays high until after DONE.
REQ-033 Assert reset at edge 3 of a shamt=10 SLL -> outputs read 0 immediately, no done pulse; a new request after release completes correctly.
REQ-034 Randomized op, a, and shamt against a reference model (<<, >>, >>>, rotate) -> result and latency match on every transaction.

Source files
------------

// File: rtl/shift_unit_seq.sv
// shift_unit_seq: sequential 32-bit shifter that shifts one bit per clock.
// Supported operations are SLL, SRL, SRA and ROL.
// A request is accepted in IDLE. The block then shifts for shamt edges and
// pulses done for one cycle. result holds its value until the next request
// is accepted.
module shift_unit_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [4:0]  shamt,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [4:0]  cnt;
    logic [1:0]  opr;
    logic [31:0] shifted;

    // State register; reset abandons any operation in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic. start is only looked at in IDLE.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (shamt == 5'd0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == 5'd1) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Single-bit shift of the current result, using the latched op.
    always_comb begin
        shifted = result;
        case (opr)
            2'b00:   shifted = {result[30:0], 1'b0};
            2'b01:   shifted = {1'b0, result[31:1]};
            2'b10:   shifted = {result[31], result[31:1]};
            default: shifted = {result[30:0], result[31]};
        endcase
    end

    // Datapath registers: capture the operands on acceptance, then shift and
    // count down while in SHIFT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            opr    <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        result <= a;
                        cnt    <= shamt;
                        opr    <= op;
                    end
                end
                SHIFT: begin
                    result <= shifted;
                    cnt    <= cnt - 5'd1;
                end
                default: ;
            endcase
        end
    end

    // Status outputs are decoded directly from the state.
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed testbench for shift_unit_seq. It uses immediate assertions and
// compares against hand-computed values and a behavioural shift model.
module tb_shift_unit_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [4:0]  shamt;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int unsigned checks;
    int unsigned errors;

    shift_unit_seq dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .shamt  (shamt),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] v, input logic [4:0] s);
        logic [31:0] r;
        case (o)
            2'b00:   r = v << s;
            2'b01:   r = v >> s;
            2'b10:   r = $unsigned($signed(v) >>> s);
            default: r = (s == 5'd0) ? v : ((v << s) | (v >> (6'd32 - {1'b0, s})));
        endcase
        return r;
    endfunction

    // Issues one request and checks the latency, the result and the
    // single-cycle done pulse. It must be called 1 ns after a rising edge
    // with the DUT in IDLE, and it returns in that same condition.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] av,
                          input logic [4:0] sh, input logic [31:0] exp);
        int unsigned edges;
        start = 1'b1;
        op    = o;
        a     = av;
        shamt = sh;
        @(posedge clk);
        #1;
        start = 1'b0;
        // Scramble the inputs after acceptance; they must not matter now.
        op    = ~o;
        a     = ~av;
        shamt = ~sh;
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        edges = 0;
        while (!done && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
            if (!done) check({tag, "_busy_mid"}, {31'd0, busy}, 32'd1);
        end
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_lat"}, edges, {27'd0, sh});
        check({tag, "_res"}, result, exp);
        @(posedge clk);
        #1;
        check({tag, "_done_off"}, {31'd0, done}, 32'd0);
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
        check({tag, "_hold"}, result, exp);
    endtask

    initial begin
        int unsigned edges;
        int unsigned done_cnt;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [4:0]  rs;

        checks = 0;
        errors = 0;
        reset  = 1'b1;
        start  = 1'b0;
        op     = 2'b00;
        a      = '0;
        shamt  = '0;

        // The reset state must be visible before any clock edge.
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_res", result, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Hand-computed vectors.
        run_op("sll4",    2'b00, 32'h0000_0001, 5'd4,  32'h0000_0010);
        run_op("sra31",   2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
        run_op("srl31",   2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001);
        run_op("rol1",    2'b11, 32'h8000_0001, 5'd1,  32'h0000_0003);
        run_op("rol0",    2'b11, 32'h8000_0001, 5'd0,  32'h8000_0001);
        run_op("sra4pos", 2'b10, 32'h7000_0000, 5'd4,  32'h0700_0000);
        run_op("rol8",    2'b11, 32'h1234_5678, 5'd8,  32'h3456_7812);
        run_op("sll31",   2'b00, 32'h0000_0003, 5'd31, 32'h8000_0000);

        // A start pulse during SHIFT must be ignored and must not be queued.
        start = 1'b1;
        op    = 2'b01;
        a     = 32'hF000_0000;
        shamt = 5'd8;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b1;
        op    = 2'b00;
        a     = 32'h0000_00FF;
        shamt = 5'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        edges    = 2;
        done_cnt = 0;
        while (!done && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check("ign_lat", edges, 32'd8);
        check("ign_res", result, 32'h00F0_0000);
        check("ign_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
        end
        check("ign_one_pulse", done_cnt, 32'd0);
        check("ign_idle", {31'd0, busy}, 32'd0);
        check("ign_hold", result, 32'h00F0_0000);

        // Reset in the middle of an operation abandons it without a done pulse.
        start = 1'b1;
        op    = 2'b00;
        a     = 32'h0000_0001;
        shamt = 5'd10;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_res", result, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) done_cnt++;
        end
        check("mid_rst_quiet", done_cnt, 32'd0);
        run_op("post_rst", 2'b00, 32'h0000_0001, 5'd10, 32'h0000_0400);

        // Random transactions checked against the behavioural model.
        for (int i = 0; i < 8; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rs = 5'($urandom_range(0, 31));
            run_op($sformatf("rnd%0d", i), ro, ra, rs, ref_shift(ro, ra, rs));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
